// File: rtl/processador_multiciclo_param_pkg.sv
// ============================================================================
// Package     : proc_multiciclo_pkg
// Description : Shared definitions for the parametrised multicycle processor.
//               Holds opcode encodings, Tstep state encoding, and a helper
//               that packs an instruction word from (op, rx, ry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_multiciclo_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_t;

  // Packs {op, rx, ry} with register fields of width rw, right-aligned.
  function automatic logic [31:0] make_ir(input logic [2:0] op,
                                          input int unsigned rx,
                                          input int unsigned ry,
                                          input int unsigned rw);
    int unsigned mask;
    mask = (32'd1 << rw) - 32'd1;
    return (32'(op) << (2 * rw)) | ((rx & mask) << rw) | (ry & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/processador_multiciclo_param_if.sv
// ============================================================================
// Interface   : processador_multiciclo_param_if
// Description : Processor bus bundle: instruction/immediate input, start
//               request, step-complete flag and the shared data bus.
//               master = environment side, slave = processor side.
// Ports       : DIN (DATA_W), Run, Done, BusWires (DATA_W)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface processador_multiciclo_param_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic [DATA_W-1:0] BusWires;

  modport master (output DIN, output Run, input Done, input BusWires);
  modport slave  (input DIN, input Run, output Done, output BusWires);
endinterface

`default_nettype wire

// File: rtl/processador_multiciclo_param_registrador.sv
// ============================================================================
// Module      : registrador_param
// Description : W-bit register with load enable and asynchronous
//               active-high clear.
// Ports       : clk, rst, i_en, i_d[W-1:0] -> o_q[W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registrador_param #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_en,
  input  wire logic [W-1:0] i_d,
  output logic      [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/processador_multiciclo_param.sv
// ============================================================================
// Module      : processador_multiciclo_param
// Description : Parametrised multicycle processor. Instruction latched from
//               DIN into IR at T0, then executed over T1..T3 on a shared
//               bus. Ops: mv, mvi, add, sub, and; optional mvnz.
// Ports       : Clock, Reset (async, active-high),
//               bus (slave): DIN, Run in; Done, BusWires out
// Config      : PROC_MVNZ_EN - compiles in opcode 101 (mvnz Rx,Ry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processador_multiciclo_param
  import proc_multiciclo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input wire logic Clock,
  input wire logic Reset,
  processador_multiciclo_param_if.slave bus
);

  localparam int RW   = $clog2(NREG);
  localparam int IR_W = 3 + 2 * RW;

  tstep_t            r_tstep, w_tstep_next;
  logic [IR_W-1:0]   w_ir;
  logic [2:0]        w_op;
  logic [RW-1:0]     w_rx, w_ry;
  logic [DATA_W-1:0] w_regs [NREG];
  logic [DATA_W-1:0] w_a, w_g, w_alu, w_bus;
  logic [NREG-1:0]   w_rin, w_rout;
  logic              w_done, w_irin, w_dinout, w_ain, w_gin, w_gout, w_is_alu;

  assign w_op     = w_ir[IR_W-1 -: 3];
  assign w_rx     = w_ir[2*RW-1 -: RW];
  assign w_ry     = w_ir[RW-1:0];
  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND);

`ifdef PROC_MVNZ_EN
  logic w_g_nz;
  assign w_g_nz = |w_g;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_tstep <= T0;
    else       r_tstep <= w_tstep_next;
  end

  always_comb begin
    w_done   = 1'b0;
    w_irin   = 1'b0;
    w_dinout = 1'b0;
    w_ain    = 1'b0;
    w_gin    = 1'b0;
    w_gout   = 1'b0;
    w_rin    = '0;
    w_rout   = '0;
    case (r_tstep)
      T0: begin
        if (bus.Run) begin
          w_dinout = 1'b1;
          w_irin   = 1'b1;
        end
      end
      T1: begin
        if (w_op == OP_MV) begin
          w_rout[w_ry] = 1'b1;
          w_rin[w_rx]  = 1'b1;
          w_done       = 1'b1;
        end else if (w_op == OP_MVI) begin
          w_dinout     = 1'b1;
          w_rin[w_rx]  = 1'b1;
          w_done       = 1'b1;
        end else if (w_is_alu) begin
          w_rout[w_rx] = 1'b1;
          w_ain        = 1'b1;
`ifdef PROC_MVNZ_EN
        end else if (w_op == OP_MVNZ) begin
          w_done = 1'b1;
          if (w_g_nz) begin
            w_rout[w_ry] = 1'b1;
            w_rin[w_rx]  = 1'b1;
          end
`endif
        end else begin
          // Illegal opcode: finish without touching any register.
          w_done = 1'b1;
        end
      end
      T2: begin
        if (w_is_alu) begin
          w_rout[w_ry] = 1'b1;
          w_gin        = 1'b1;
        end else begin
          w_done = 1'b1;  // unreachable; returns to T0 if ever entered
        end
      end
      default: begin  // T3
        if (w_is_alu) begin
          w_gout      = 1'b1;
          w_rin[w_rx] = 1'b1;
        end
        w_done = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (r_tstep == T0 && !bus.Run) w_tstep_next = T0;
    else if (w_done)               w_tstep_next = T0;
    else                           w_tstep_next = tstep_t'(r_tstep + 2'd1);
  end

  always_comb begin
    case (w_op)
      OP_SUB:  w_alu = w_a + ~w_bus + DATA_W'(1);
      OP_AND:  w_alu = w_a & w_bus;
      default: w_alu = w_a + w_bus;
    endcase
  end

  // Scan high to low so the lowest-index register wins; Gout and DINout
  // override afterwards, giving DINout > Gout > Rout[lowest].
  always_comb begin
    w_bus = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_rout[i]) w_bus = w_regs[i];
    end
    if (w_gout)   w_bus = w_g;
    if (w_dinout) w_bus = bus.DIN;
  end

  registrador_param #(.W(IR_W)) u_ir (
    .clk(Clock), .rst(Reset), .i_en(w_irin), .i_d(bus.DIN[IR_W-1:0]), .o_q(w_ir)
  );
  registrador_param #(.W(DATA_W)) u_a (
    .clk(Clock), .rst(Reset), .i_en(w_ain), .i_d(w_bus), .o_q(w_a)
  );
  registrador_param #(.W(DATA_W)) u_g (
    .clk(Clock), .rst(Reset), .i_en(w_gin), .i_d(w_alu), .o_q(w_g)
  );

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
      registrador_param #(.W(DATA_W)) u_reg (
        .clk(Clock), .rst(Reset), .i_en(w_rin[gi]), .i_d(w_bus), .o_q(w_regs[gi])
      );
    end
  endgenerate

  assign bus.Done     = w_done;
  assign bus.BusWires = w_bus;

endmodule

`default_nettype wire

// File: tb/tb_processador_multiciclo_param.sv
// ============================================================================
// Module      : tb_processador_multiciclo_param
// Description : Self-checking bench for processador_multiciclo_param.
//               dut  : DATA_W=16, NREG=8 (full directed sequence)
//               dut2 : DATA_W=32, NREG=16 (mvi/add repeat)
//               Honours PROC_MVNZ_EN for the mvnz expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processador_multiciclo_param;
  import proc_multiciclo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  processador_multiciclo_param_if #(.DATA_W(16)) b1 ();
  processador_multiciclo_param_if #(.DATA_W(32)) b2 ();

  processador_multiciclo_param #(.DATA_W(16), .NREG(8)) dut (
    .Clock(clk), .Reset(rst), .bus(b1.slave)
  );
  processador_multiciclo_param #(.DATA_W(32), .NREG(16)) dut2 (
    .Clock(clk), .Reset(rst), .bus(b2.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          npass = 0;
  int          ntot  = 0;
  logic [15:0] m_r [8];
  logic [15:0] m_a, m_g;
  logic [8:0]  m_ir;
  logic [31:0] m2 [16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    ntot++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) npass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
  endtask

  function automatic logic [15:0] ir16(input logic [2:0] op, input int rx, input int ry);
    logic [31:0] t;
    t = make_ir(op, rx, ry, 3);
    return t[15:0];
  endfunction

  task automatic t_mvi(input int rx, input logic [15:0] v);
    m_ir = ir16(OP_MVI, rx, 0) & 16'h01FF;
    push("mvi_done_t1", 1);
    push("mvi_bus_t1", 32'(v));
    push("mvi_reg", 32'(v));
    push("mvi_tstep_end", 0);
    b1.Run = 1'b1; b1.DIN = ir16(OP_MVI, rx, 0);
    cyc();
    b1.Run = 1'b0; b1.DIN = v;
    #1;
    chk(32'(b1.Done));
    chk(32'(b1.BusWires));
    cyc();
    b1.DIN = '0;
    m_r[rx] = v;
    chk(32'(dut.w_regs[rx]));
    chk(32'(dut.r_tstep));
  endtask

  task automatic t_alu(input logic [2:0] op, input int rx, input int ry);
    logic [15:0] a, b, res;
    a = m_r[rx];
    b = m_r[ry];
    case (op)
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      default: res = a + b;
    endcase
    m_ir = ir16(op, rx, ry) & 16'h01FF;
    push("alu_done_t1", 0);
    push("alu_a_t2", 32'(a));
    push("alu_g_t3", 32'(res));
    push("alu_bus_t3", 32'(res));
    push("alu_done_t3", 1);
    push("alu_reg", 32'(res));
    push("alu_tstep_end", 0);
    b1.Run = 1'b1; b1.DIN = ir16(op, rx, ry);
    cyc();
    b1.Run = 1'b0; b1.DIN = '0;
    #1;
    chk(32'(b1.Done));
    cyc();
    chk(32'(dut.w_a));
    cyc();
    chk(32'(dut.w_g));
    #1;
    chk(32'(b1.BusWires));
    chk(32'(b1.Done));
    cyc();
    m_r[rx] = res; m_a = a; m_g = res;
    chk(32'(dut.w_regs[rx]));
    chk(32'(dut.r_tstep));
  endtask

  // One-step instructions (mv, mvnz, illegal): Done in T1, optional write.
  task automatic t_one(input logic [2:0] op, input int rx, input int ry, input bit wr);
    m_ir = ir16(op, rx, ry) & 16'h01FF;
    push("one_done_t1", 1);
    push("one_reg", 32'(wr ? m_r[ry] : m_r[rx]));
    push("one_a", 32'(m_a));
    push("one_g", 32'(m_g));
    push("one_tstep_end", 0);
    b1.Run = 1'b1; b1.DIN = ir16(op, rx, ry);
    cyc();
    b1.Run = 1'b0; b1.DIN = '0;
    #1;
    chk(32'(b1.Done));
    cyc();
    if (wr) m_r[rx] = m_r[ry];
    chk(32'(dut.w_regs[rx]));
    chk(32'(dut.w_a));
    chk(32'(dut.w_g));
    chk(32'(dut.r_tstep));
  endtask

  task automatic t2_mvi(input int rx, input logic [31:0] v);
    logic [31:0] t;
    t = make_ir(OP_MVI, rx, 0, 4);
    push("w32_mvi_done_t1", 1);
    push("w32_mvi_reg", v);
    push("w32_mvi_tstep_end", 0);
    b2.Run = 1'b1; b2.DIN = t;
    cyc();
    b2.Run = 1'b0; b2.DIN = v;
    #1;
    chk(32'(b2.Done));
    cyc();
    b2.DIN = '0;
    m2[rx] = v;
    chk(dut2.w_regs[rx]);
    chk(32'(dut2.r_tstep));
  endtask

  task automatic t2_add(input int rx, input int ry);
    logic [31:0] t, res;
    t   = make_ir(OP_ADD, rx, ry, 4);
    res = m2[rx] + m2[ry];
    push("w32_add_a_t2", m2[rx]);
    push("w32_add_g_t3", res);
    push("w32_add_bus_t3", res);
    push("w32_add_done_t3", 1);
    push("w32_add_reg", res);
    b2.Run = 1'b1; b2.DIN = t;
    cyc();
    b2.Run = 1'b0; b2.DIN = '0;
    cyc();
    chk(dut2.w_a);
    cyc();
    chk(dut2.w_g);
    #1;
    chk(b2.BusWires);
    chk(32'(b2.Done));
    cyc();
    m2[rx] = res;
    chk(dut2.w_regs[rx]);
  endtask

  initial begin
    b1.Run = 1'b0; b1.DIN = '0;
    b2.Run = 1'b0; b2.DIN = '0;
    for (int i = 0; i < 8; i++)  m_r[i] = '0;
    for (int i = 0; i < 16; i++) m2[i]  = '0;
    m_a = '0; m_g = '0; m_ir = '0;

    // Reset state
    cyc();
    push("rst_tstep", 0); push("rst_done", 0); push("rst_bus", 0);
    push("rst_r0", 0);    push("rst_ir", 0);
    chk(32'(dut.r_tstep)); chk(32'(b1.Done)); chk(32'(b1.BusWires));
    chk(32'(dut.w_regs[0])); chk(32'(dut.w_ir));
    cyc();
    rst = 1'b0;

    // 1: mvi R0,5
    t_mvi(0, 16'h0005);
    // 2: add R0,R1
    t_mvi(1, 16'h0003);
    t_alu(OP_ADD, 0, 1);
    // 3: sub wrap, and to zero
    t_mvi(2, 16'h0000);
    t_mvi(3, 16'h0001);
    t_alu(OP_SUB, 2, 3);
    t_mvi(3, 16'h00F0);
    t_mvi(2, 16'h0F0F);
    t_alu(OP_AND, 2, 3);
    // Rx==Ry on an ALU op: R3 = 0xF0 + 0xF0
    t_alu(OP_ADD, 3, 3);
    // Illegal opcode 110
    t_one(3'b110, 2, 3, 1'b0);

    // 4: Run=0 with a valid DIN holds everything
    b1.DIN = ir16(OP_MVI, 7, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      push("idle_tstep", 0); push("idle_done", 0); push("idle_bus", 0);
      chk(32'(dut.r_tstep)); chk(32'(b1.Done)); chk(32'(b1.BusWires));
    end
    push("idle_ir", 32'(m_ir)); push("idle_r7", 32'(m_r[7]));
    chk(32'(dut.w_ir)); chk(32'(dut.w_regs[7]));
    b1.DIN = '0;

    // 5: Reset during T2 of add R0,R1
    b1.Run = 1'b1; b1.DIN = ir16(OP_ADD, 0, 1);
    cyc();
    b1.Run = 1'b0; b1.DIN = '0;
    cyc();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_a = '0; m_g = '0; m_ir = '0;
    push("mid_rst_tstep", 0); push("mid_rst_done", 0); push("mid_rst_r0", 0);
    push("mid_rst_a", 0);     push("mid_rst_g", 0);    push("mid_rst_ir", 0);
    chk(32'(dut.r_tstep)); chk(32'(b1.Done)); chk(32'(dut.w_regs[0]));
    chk(32'(dut.w_a));     chk(32'(dut.w_g));  chk(32'(dut.w_ir));
    cyc();
    rst = 1'b0;
    t_mvi(4, 16'h0077);
    t_one(OP_MV, 4, 4, 1'b1);
    t_one(OP_MV, 5, 4, 1'b1);

    // 6: mvnz R5,R6 with G==0 then G==8
    t_mvi(6, 16'h1234);
    t_mvi(5, 16'h0055);
    t_one(OP_MVNZ, 5, 6, 1'b0);
    t_mvi(0, 16'h0005);
    t_mvi(1, 16'h0003);
    t_alu(OP_ADD, 0, 1);
`ifdef PROC_MVNZ_EN
    t_one(OP_MVNZ, 5, 6, 1'b1);
`else
    t_one(OP_MVNZ, 5, 6, 1'b0);
`endif

    // Wide configuration: DATA_W=32, NREG=16
    t2_mvi(0, 32'h0000_0005);
    t2_mvi(1, 32'h0000_0003);
    t2_add(0, 1);
    t2_mvi(15, 32'hFFFF_FFFF);
    t2_add(15, 0);

    if (sb.size() != 0) begin
      ntot++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
